// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, default lane count and latency counter width.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int BYTE_LANES = 4;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel between the core (master) and the memory responder (slave).
interface mem_responder_if #(
  parameter int ADDRESS_WIDTH = 17,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8
);
  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;

  logic                     req_valid;
  logic                     req_ready;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic                     req_we;
  logic [LANES-1:0]         req_be;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic                     rsp_write;

  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_write
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_write
  );

endinterface

// File: rtl/mem_responder_byte_lane_ram.sv
// Word-organised storage with per-lane write enables.
// Synchronous write, asynchronous word read (read sees pre-write contents on the write edge).
module byte_lane_ram
  import mem_if_pkg::*;
#(
  parameter int WORD_AW    = 15,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int LANES      = BYTE_LANES
) (
  input  logic                  clk,
  input  logic [LANES-1:0]      we,
  input  logic [WORD_AW-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [WORD_AW-1:0]    raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**WORD_AW];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) begin
        mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder with a fixed access latency.
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// WAIT  | request latched, counting down the remaining latency
// RESP  | response presented, held until rsp_ready
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 17,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int LATENCY       = 2
) (
  input logic            CLK,
  input logic            RST,
  mem_responder_if.slave bus
);

  localparam int LANES   = DATA_WIDTH / BYTE_WIDTH;
  localparam int LSB_W   = $clog2(LANES);
  localparam int WORD_AW = ADDRESS_WIDTH - LSB_W;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [WORD_AW-1:0]    word_q;
  logic                  we_q;
  logic [LANES-1:0]      be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rsp_valid_q;
  logic                  rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic [WORD_AW-1:0]    cur_word;
  logic                  cur_we;
  logic [LANES-1:0]      cur_be;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic                  accept;
  logic                  complete;
  logic [LANES-1:0]      ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  addr_lsb_unused;

  // Byte offset within the word never affects the access.
  assign addr_lsb_unused = ^bus.req_addr[LSB_W-1:0];

  assign accept = (state == IDLE) && bus.req_valid;

  // With LATENCY==1 the accept edge is also the completion edge, so the
  // live request fields drive the array directly.
  always_comb begin
    cur_word  = word_q;
    cur_we    = we_q;
    cur_be    = be_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_word  = bus.req_addr[ADDRESS_WIDTH-1:LSB_W];
      cur_we    = bus.req_we;
      cur_be    = bus.req_be;
      cur_wdata = bus.req_wdata;
    end
  end

  // Reset blocks a store that would otherwise land on this edge.
  assign complete = !RST && ((accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == '0)));
  assign ram_we   = (complete && cur_we) ? cur_be : '0;

  byte_lane_ram #(
    .WORD_AW    (WORD_AW),
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .LANES      (LANES)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .waddr (cur_word),
    .wdata (cur_wdata),
    .raddr (cur_word),
    .rdata (ram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      word_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            word_q  <= cur_word;
            we_q    <= cur_we;
            be_q    <= cur_be;
            wdata_q <= cur_wdata;
            if (LATENCY == 1) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_write_q <= cur_we;
              rsp_rdata_q <= cur_we ? '0 : ram_rdata;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= cur_we;
            rsp_rdata_q <= cur_we ? '0 : ram_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 1, 3) against a byte-level transaction model.
module tb_mem_responder;

  localparam int AW = 17;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int NL = DW / BW;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid [NI];
  logic          req_we    [NI];
  logic [AW-1:0] req_addr  [NI];
  logic [NL-1:0] req_be    [NI];
  logic [DW-1:0] req_wdata [NI];
  logic          rsp_ready [NI];
  logic          req_ready [NI];
  logic          rsp_valid [NI];
  logic          rsp_write [NI];
  logic [DW-1:0] rsp_rdata [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 1) ? 1 : ((g == 2) ? 3 : 2);
    mem_responder_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();
    assign bus.req_valid = req_valid[g];
    assign bus.req_we    = req_we[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_be    = req_be[g];
    assign bus.req_wdata = req_wdata[g];
    assign bus.rsp_ready = rsp_ready[g];
    assign req_ready[g]  = bus.req_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_write[g]  = bus.rsp_write;
    assign rsp_rdata[g]  = bus.rsp_rdata;
    mem_responder #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .BYTE_WIDTH    (BW),
      .LATENCY       (L)
    ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
    );
  end

  function automatic int lat_of(int k);
    return (k == 1) ? 1 : ((k == 2) ? 3 : 2);
  endfunction

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h want=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // Transaction-level model: counts edges since accept, byte-addressed memory.
  logic [7:0]    mm [int];
  bit            m_busy [NI];
  bit            m_resp [NI];
  int            m_n    [NI];
  logic          m_we   [NI];
  logic [AW-1:0] m_addr [NI];
  logic [NL-1:0] m_be   [NI];
  logic [DW-1:0] m_wd   [NI];
  logic [DW-1:0] m_rd   [NI];
  logic          m_wr   [NI];

  function automatic int mkey(int k, int a);
    return k * (1 << AW) + a;
  endfunction

  task automatic m_complete(int k);
    int base;
    logic [DW-1:0] w;
    base = int'(m_addr[k]) & ~(NL - 1);
    m_resp[k] = 1'b1;
    if (m_we[k]) begin
      for (int i = 0; i < NL; i++)
        if (m_be[k][i]) mm[mkey(k, base + i)] = m_wd[k][i*BW +: BW];
      m_rd[k] = '0;
      m_wr[k] = 1'b1;
    end else begin
      for (int i = 0; i < NL; i++)
        w[i*BW +: BW] = mm.exists(mkey(k, base + i)) ? mm[mkey(k, base + i)] : 8'hxx;
      m_rd[k] = w;
      m_wr[k] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0;
        m_resp[k] = 1'b0;
        m_rd[k]   = '0;
        m_wr[k]   = 1'b0;
      end else if (!m_busy[k]) begin
        if (req_valid[k]) begin
          m_busy[k] = 1'b1;
          m_n[k]    = 1;
          m_we[k]   = req_we[k];
          m_addr[k] = req_addr[k];
          m_be[k]   = req_be[k];
          m_wd[k]   = req_wdata[k];
          if (m_n[k] == lat_of(k)) m_complete(k);
        end
      end else if (!m_resp[k]) begin
        m_n[k]++;
        if (m_n[k] == lat_of(k)) m_complete(k);
      end else if (rsp_ready[k]) begin
        m_busy[k] = 1'b0;
        m_resp[k] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        chk("model_req_ready", k, 32'(req_ready[k]), 32'(!m_busy[k]));
        chk("model_rsp_valid", k, 32'(rsp_valid[k]), 32'(m_resp[k]));
        chk("model_rsp_write", k, 32'(rsp_write[k]), 32'(m_wr[k]));
        chk("model_rsp_rdata", k, rsp_rdata[k], m_rd[k]);
      end
    end
  end

  task automatic txn(input int k, input logic we, input logic [AW-1:0] addr,
                     input logic [NL-1:0] be, input logic [DW-1:0] wd,
                     input int hold, input logic [DW-1:0] exp_rd, input int exp_lat);
    int  lat;
    bit  seen;
    @(negedge clk);
    chk("idle_ready", k, 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_be[k]    = be;
    req_wdata[k] = wd;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_we[k]    = ~we;
    req_addr[k]  = AW'($urandom);
    req_be[k]    = NL'($urandom);
    req_wdata[k] = $urandom;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 40) begin
      @(negedge clk);
      if (rsp_valid[k] === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout inst=%0d got=no_rsp want=rsp_after_%0d_edges", k, exp_lat);
      return;
    end
    chk("latency", k, 32'(lat), 32'(exp_lat));
    chk("rsp_rdata", k, rsp_rdata[k], exp_rd);
    chk("rsp_write", k, 32'(rsp_write[k]), 32'(we));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", k, 32'(rsp_valid[k]), 32'd1);
      chk("hold_rdata", k, rsp_rdata[k], exp_rd);
      chk("hold_busy", k, 32'(req_ready[k]), 32'd0);
    end
    @(negedge clk);
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b0;
    @(negedge clk);
    chk("back_idle", k, 32'(req_ready[k]), 32'd1);
    chk("rsp_dropped", k, 32'(rsp_valid[k]), 32'd0);
    chk("rdata_held", k, rsp_rdata[k], exp_rd);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = '0;
      req_be[k]    = '0;
      req_wdata[k] = '0;
      rsp_ready[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_req_ready", k, 32'(req_ready[k]), 32'd1);
      chk("rst_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
      chk("rst_rsp_rdata", k, rsp_rdata[k], 32'h0);
      chk("rst_rsp_write", k, 32'(rsp_write[k]), 32'd0);
    end
    chk_en = 1'b1;
    rst    = 1'b0;

    // LATENCY=2: full store then load
    txn(0, 1'b1, 17'h00100, 4'b1111, 32'hDEADBEEF, 0, 32'h0, 2);
    txn(0, 1'b0, 17'h00100, 4'b0000, 32'h0,        0, 32'hDEADBEEF, 2);
    // partial store, unaligned addresses
    txn(0, 1'b1, 17'h00200, 4'b1111, 32'h11223344, 0, 32'h0, 2);
    txn(0, 1'b1, 17'h00201, 4'b0010, 32'h0000AA00, 0, 32'h0, 2);
    txn(0, 1'b0, 17'h00203, 4'b1111, 32'h0,        0, 32'h1122AA44, 2);
    // backpressure
    txn(0, 1'b0, 17'h00200, 4'b0000, 32'h0,        5, 32'h1122AA44, 2);
    // highest word
    txn(0, 1'b1, 17'h1FFFF, 4'b1111, 32'hA5A55A5A, 0, 32'h0, 2);
    txn(0, 1'b0, 17'h1FFFC, 4'b0000, 32'h0,        0, 32'hA5A55A5A, 2);

    // LATENCY=1 and an empty-lane store
    txn(1, 1'b1, 17'h00300, 4'b1111, 32'h12345678, 0, 32'h0, 1);
    txn(1, 1'b1, 17'h00300, 4'b0000, 32'hFFFFFFFF, 2, 32'h0, 1);
    txn(1, 1'b0, 17'h00300, 4'b1111, 32'h0,        0, 32'h12345678, 1);

    // LATENCY=3: reset lands on the would-be completion edge of a store
    txn(2, 1'b1, 17'h00400, 4'b1111, 32'h0BADC0DE, 0, 32'h0, 3);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 17'h00400;
    req_be[2]    = 4'b1111;
    req_wdata[2] = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_wait", 2, 32'(req_ready[2]), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 2, 32'(rsp_valid[2]), 32'd0);
    end
    txn(2, 1'b0, 17'h00400, 4'b0000, 32'h0, 0, 32'h0BADC0DE, 3);
    txn(0, 1'b0, 17'h00100, 4'b0000, 32'h0, 0, 32'hDEADBEEF, 2);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=still_running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the core's data-memory interface. It serves one outstanding load/store at a time over a valid/ready request channel and a valid/ready response channel, with a configurable access latency. Per-byte write enables follow the same lane convention as the core's WE0..WE3. Loads always return the full aligned word; the core performs byte/half extraction.

Parameters:
ADDRESS_WIDTH, 17, byte-address width; storage is 2^ADDRESS_WIDTH bytes
DATA_WIDTH, 32, word width
BYTE_WIDTH, 8, lane width; lanes = DATA_WIDTH/BYTE_WIDTH
LATENCY, 2, clock edges from request accept to rsp_valid high; legal range 1..15

Ports:
CLK  in  1  clock
RST  in  1  reset; synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_addr  in  ADDRESS_WIDTH  byte address
req_we  in  1  1 = store, 0 = load
req_be  in  DATA_WIDTH/BYTE_WIDTH  byte-lane write enables; bit i is lane i (little-endian)
req_wdata  in  DATA_WIDTH  store data, lane-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  initiator accepts response
rsp_rdata  out  DATA_WIDTH  load data (full word); 0 for stores
rsp_write  out  1  response belongs to a store

Behaviour:
- Reset state: IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_write=0, latency counter=0. Memory contents are not reset.
- States are IDLE, WAIT and RESP.
  - req_ready = (state==IDLE), decoded from the state register only. There is no combinational path from any input.
- IDLE:
  - On req_valid&&req_ready, latch addr, we, be and wdata.
  - LATENCY==1: go to RESP. Otherwise go to WAIT with cnt=LATENCY-2.
- WAIT: cnt decrements each edge; at cnt==0 go to RESP.
- Completion edge (the edge entering RESP):
  - Store: lanes with be[i]=1 are written at word_base+i, where word_base = {addr[AW-1:2],2'b00}. addr[1:0] is ignored. rsp_rdata<=0 and rsp_write<=1.
  - Load: rsp_rdata<=mem word at word_base, pre-write contents. rsp_write<=0. be is ignored.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_write are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE with rsp_valid<=0. rsp_rdata holds its last value.
- Throughput: one transaction per LATENCY+1 edges minimum. No request is accepted while in WAIT/RESP, so requests stall.
- Store with be=0: memory is unchanged, and the store is still acknowledged.
- Highest word (addr all ones in the upper bits): no wrap past the array end, because word_base plus 3 stays in range by construction.
- RST mid-operation (WAIT or RESP):
  - The transaction is dropped and no response is issued.
  - A store not yet at its completion edge is never written.
  - RST has priority over every state transition on the same edge.
- Inputs on the request channel are sampled only at the accept edge. Later changes have no effect.

Decomposition:
- Package mem_if_pkg:
  - state enum (IDLE, WAIT, RESP)
  - BYTE_LANES localparam
  - counter width constant (4 bits)
- One sub-module, byte_lane_ram: a word-organised array with per-lane write enables, a synchronous write and an asynchronous word read. It is instantiated once; the FSM, counter and response registers stay in mem_responder.

Test Plan:
- Reset then idle: RST=1 for 2 edges -> req_ready=1, rsp_valid=0, rsp_rdata=0.
- Store then load, LATENCY=2: store addr 0x100, be=4'b1111, wdata=0xDEADBEEF. Then load at 0x100 -> rsp_valid rises exactly 2 edges after accept; load returns 0xDEADBEEF with rsp_write=0.
- Partial store: store 0x11223344 at 0x200 with be=1111, then be=0010 with wdata=0x0000AA00, then load 0x203 -> 0x1122AA44 (addr[1:0] ignored).
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout. rsp_ready=1 -> IDLE next edge.
- LATENCY=1 and a be=0 store: the response arrives 1 edge after accept; memory word 0x300 is unchanged on readback.
- Reset mid-store: accept a store of 0xCAFEF00D at 0x400 with LATENCY=3, assert RST in WAIT -> no rsp_valid. A later load of 0x400 returns the prior contents.
